// File: rtl/bnn_argmax_readout.sv
// Argmax readout for the bnn output layer: on a rising bnn_done it reads the
// class scores from activation memory and hands the signed winner to the host.
module bnn_argmax_readout #(
    parameter int ADDR_W      = 11,
    parameter int DATA_W      = 8,
    parameter int NUM_CLASSES = 10,
    parameter int BASE_ADDR   = 1024,
    parameter int RD_LAT      = 1,
    parameter int CLASS_W     = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               bnn_done,
    input  logic [DATA_W-1:0]  activation_out,
    output logic [ADDR_W-1:0]  activation_addr_rd,
    output logic               busy,
    output logic               result_valid,
    input  logic               result_ready,
    output logic [CLASS_W-1:0] result_class,
    output logic [DATA_W-1:0]  result_score,
    output logic               overrun
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, HOLD} state_t;

    localparam logic [CLASS_W-1:0] LAST_CLS = CLASS_W'(NUM_CLASSES - 1);
    localparam logic [ADDR_W-1:0]  BASE     = ADDR_W'(BASE_ADDR);

    state_t                   state;
    state_t                   state_nxt;
    logic                     done_q;
    logic                     start;
    logic [CLASS_W-1:0]       cnt;
    logic [RD_LAT-1:0]        tag_vld_p;
    logic [CLASS_W-1:0]       tag_cls_p [RD_LAT];
    logic                     take;
    logic                     take_last;
    logic [CLASS_W-1:0]       take_cls;
    logic signed [DATA_W-1:0] sample;
    logic signed [DATA_W-1:0] best_score;
    logic [CLASS_W-1:0]       best_class;

    // Strict greater-than keeps the lowest index on ties; class 0 always loads.
    function automatic logic beats(input logic signed [DATA_W-1:0] cand,
                                   input logic signed [DATA_W-1:0] best,
                                   input logic                     first);
        return first || (cand > best);
    endfunction

    assign start     = bnn_done & ~done_q;
    assign sample    = activation_out;
    assign take      = tag_vld_p[RD_LAT-1];
    assign take_cls  = tag_cls_p[RD_LAT-1];
    assign take_last = take && (take_cls == LAST_CLS);

    assign busy         = (state != IDLE);
    assign result_valid = (state == HOLD);
    assign result_class = best_class;
    assign result_score = best_score;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ISSUE;
            ISSUE:   if (cnt == LAST_CLS) state_nxt = DRAIN;
            DRAIN:   if (take_last) state_nxt = HOLD;
            HOLD:    if (result_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Address generation, edge detect and the read-latency tag pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_q             <= 1'b1;
            overrun            <= 1'b0;
            activation_addr_rd <= '0;
            cnt                <= '0;
            tag_vld_p          <= '0;
        end else begin
            done_q       <= bnn_done;
            overrun      <= start && (state != IDLE);
            tag_vld_p[0] <= (state == ISSUE);
            for (int i = 1; i < RD_LAT; i++) tag_vld_p[i] <= tag_vld_p[i-1];
            case (state)
                IDLE: begin
                    if (start) begin
                        activation_addr_rd <= BASE;
                        cnt                <= '0;
                    end
                end
                ISSUE: begin
                    if (cnt != LAST_CLS) begin
                        activation_addr_rd <= activation_addr_rd + ADDR_W'(1);
                        cnt                <= cnt + CLASS_W'(1);
                    end
                end
                HOLD: begin
                    if (result_ready) activation_addr_rd <= '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        tag_cls_p[0] <= cnt;
        for (int i = 1; i < RD_LAT; i++) tag_cls_p[i] <= tag_cls_p[i-1];
    end

    // Sample stage: compare the returning score against the running best.
    always_ff @(posedge clk) begin
        if (rst) begin
            best_score <= '0;
            best_class <= '0;
        end else if (take && beats(sample, best_score, take_cls == '0)) begin
            best_score <= sample;
            best_class <= take_cls;
        end
    end

endmodule
